// File: rtl/game_event_logger_if.sv
// Valid/ready record stream from the event logger to its consumer.
// The master drives valid/data and the slave returns ready.
interface game_event_logger_if #(
  parameter int REC_W = 22
) ();
  logic             out_valid;
  logic             out_ready;
  logic [REC_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/game_event_logger.sv
// Rising-edge event logger into a FWFT FIFO: record written 1 cycle after the edge, drained by valid/ready, events dropped and counted when full.
// Define EVENT_LOGGER_TS_EN to build the free-running timestamp; otherwise the ts field reads 0.
module game_event_logger #(
  parameter int CNT_W = 5,
  parameter int TS_W  = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_winner,
  input  logic                     i_loser,
  input  logic                     i_gameover,
  input  logic [1:0]               i_who,
  input  logic [CNT_W-1:0]         i_count,
  game_event_logger_if.master      o_rec,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  input  logic                     i_ovf_clr,
  output logic [7:0]               o_drop_cnt
);
  localparam int REC_W = 5 + CNT_W + TS_W;
  localparam int AW    = $clog2(DEPTH);

  logic             r_w_q, r_l_q, r_g_q;
  logic [2:0]       w_rise;
  logic             w_event;
  logic             w_empty, w_full;
  logic             w_pop, w_push, w_drop;
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [REC_W-1:0] r_mem [DEPTH];
  logic [TS_W-1:0]  w_ts;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  // Previous samples load even in reset so a flag held across release is not an edge.
  always_ff @(posedge clk) begin
    r_w_q <= i_winner;
    r_l_q <= i_loser;
    r_g_q <= i_gameover;
  end

  assign w_rise  = {i_gameover & ~r_g_q, i_winner & ~r_w_q, i_loser & ~r_l_q};
  assign w_event = (|w_rise) & ~rst;

`ifdef EVENT_LOGGER_TS_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 1'b1;
  end

  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push alongside it.
  assign w_pop  = ~w_empty & o_rec.out_ready;
  assign w_push = w_event & (~w_full | w_pop);
  assign w_drop = w_event & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_rise, i_who, i_count, w_ts};
  end

  // A drop coinciding with a clear leaves a fresh count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (i_ovf_clr) begin
      r_overflow <= w_drop;
      r_drop_cnt <= {7'd0, w_drop};
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_rec.out_valid = ~w_empty;
  assign o_rec.out_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level         = r_wr_ptr - r_rd_ptr;
  assign o_overflow      = r_overflow;
  assign o_drop_cnt      = r_drop_cnt;
endmodule

// File: tb/tb_game_event_logger.sv
// Scoreboard bench for game_event_logger: directed test-plan scenarios followed by random traffic.
// Works with or without EVENT_LOGGER_TS_EN defined.
module tb_game_event_logger;
  localparam int CNT_W = 5;
  localparam int TS_W  = 12;
  localparam int DEPTH = 8;
  localparam int REC_W = 5 + CNT_W + TS_W;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             winner, loser, gameover, ovf_clr;
  logic [1:0]       who;
  logic [CNT_W-1:0] count;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [7:0]       drop_cnt;

  game_event_logger_if #(.REC_W(REC_W)) rec_if ();

  game_event_logger #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_winner   (winner),
    .i_loser    (loser),
    .i_gameover (gameover),
    .i_who      (who),
    .i_count    (count),
    .o_rec      (rec_if),
    .o_level    (level),
    .o_overflow (overflow),
    .i_ovf_clr  (ovf_clr),
    .o_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [REC_W-1:0] sb [$];

  // Reference model state, advanced when stimulus is issued.
  int       m_level = 0;
  int       m_drop  = 0;
  bit       m_ovf   = 1'b0;
  bit [2:0] m_prev  = 3'b000;
  int       pe      = 0;
  int       rst_pe  = 0;

  // Model state as it should look after the most recent posedge.
  int exp_level = 0;
  int exp_drop  = 0;
  bit exp_ovf   = 1'b0;
  bit armed     = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs for the next posedge, predict its effect, then advance.
  task automatic cyc(input bit r, input bit [2:0] f, input bit [1:0] wh,
                     input bit [CNT_W-1:0] c, input bit rdy, input bit clr);
    bit [2:0]        rise;
    bit              pop, ev, full, push, drop;
    logic [TS_W-1:0] ts;
    rst = r;
    {gameover, winner, loser} = f;
    who = wh;
    count = c;
    rec_if.out_ready = rdy;
    ovf_clr = clr;
    if (r) begin
      m_level = 0;
      m_drop  = 0;
      m_ovf   = 1'b0;
      rst_pe  = pe + 1;
    end else begin
      rise = f & ~m_prev;
      pop  = rdy && (m_level > 0);
      ev   = (rise != 3'b000);
      full = (m_level == DEPTH);
      push = ev && (!full || pop);
      drop = ev && full && !pop;
`ifdef EVENT_LOGGER_TS_EN
      ts = TS_W'(pe - rst_pe);
`else
      ts = '0;
`endif
      if (push) sb.push_back({rise, wh, c, ts});
      m_level = m_level + int'(push) - int'(pop);
      if (clr) begin
        m_ovf  = drop;
        m_drop = int'(drop);
      end else if (drop) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_prev = f;
    @(posedge clk);
    pe++;
    #1;
    if (r) sb.delete();
    exp_level = m_level;
    exp_ovf   = m_ovf;
    exp_drop  = m_drop;
    armed     = 1'b1;
  endtask

  // Monitor: status every cycle, record contents on each accepted pop.
  always @(negedge clk) begin
    if (armed) begin
      chk("level", 64'(level), 64'(exp_level));
      chk("out_valid", 64'(rec_if.out_valid), 64'(exp_level != 0));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      if (exp_level != 0 && rec_if.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_data: got %0h expected no record", rec_if.out_data);
        end else begin
          chk("out_data", 64'(rec_if.out_data), 64'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    bit [2:0] f;
    bit       rdy;
    int       dens;
    f = 3'b000;
    dens = 50;

    repeat (3) cyc(1'b1, 3'b000, 2'd0, '0, 1'b0, 1'b0);

    // Single winner edge, held high for several cycles.
    repeat (9) cyc(1'b0, 3'b000, 2'd0, '0, 1'b0, 1'b0);
    cyc(1'b0, 3'b010, 2'd0, 5'd31, 1'b0, 1'b0);
    chk("single_valid", 64'(rec_if.out_valid), 64'd1);
    repeat (4) cyc(1'b0, 3'b010, 2'd0, 5'd0, 1'b0, 1'b0);
    chk("single_hold_level", 64'(level), 64'd1);
    cyc(1'b0, 3'b000, 2'd0, 5'd0, 1'b1, 1'b0);
    chk("single_drained", 64'(level), 64'd0);

    // Gameover and winner rise together.
    cyc(1'b0, 3'b110, 2'd2, 5'd7, 1'b0, 1'b0);
    chk("simul_level", 64'(level), 64'd1);
    cyc(1'b0, 3'b000, 2'd0, 5'd0, 1'b1, 1'b0);

    // Ten loser edges into an undrained FIFO.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 3'b001, 2'd1, CNT_W'(i), 1'b0, 1'b0);
      cyc(1'b0, 3'b000, 2'd1, 5'd0, 1'b0, 1'b0);
    end
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_cnt), 64'd2);

    // Event and pop in the same cycle while full.
    cyc(1'b0, 3'b010, 2'd3, 5'd9, 1'b1, 1'b0);
    chk("full_pp_level", 64'(level), 64'd8);
    chk("full_pp_drops", 64'(drop_cnt), 64'd2);
    repeat (10) cyc(1'b0, 3'b000, 2'd0, 5'd0, 1'b1, 1'b0);
    chk("drain_level", 64'(level), 64'd0);
    cyc(1'b0, 3'b000, 2'd0, 5'd0, 1'b0, 1'b1);
    chk("clr_flag", 64'(overflow), 64'd0);
    chk("clr_drops", 64'(drop_cnt), 64'd0);

    // Reset with three records queued and winner held high.
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 3'b010, 2'd0, CNT_W'(i), 1'b0, 1'b0);
      cyc(1'b0, 3'b000, 2'd0, 5'd0, 1'b0, 1'b0);
    end
    cyc(1'b0, 3'b010, 2'd0, 5'd2, 1'b0, 1'b0);
    chk("pre_rst_level", 64'(level), 64'd3);
    cyc(1'b1, 3'b010, 2'd0, 5'd0, 1'b0, 1'b0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(rec_if.out_valid), 64'd0);
    repeat (3) cyc(1'b0, 3'b010, 2'd0, 5'd0, 1'b0, 1'b0);
    chk("rst_no_event", 64'(level), 64'd0);
    cyc(1'b0, 3'b000, 2'd0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 3'b010, 2'd1, 5'd5, 1'b0, 1'b0);
    chk("post_rst_level", 64'(level), 64'd1);
    cyc(1'b0, 3'b000, 2'd0, 5'd0, 1'b1, 1'b0);

    // Random traffic; the long reset-free tail wraps the timestamp.
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) begin
        case ($urandom_range(2))
          0:       dens = 10;
          1:       dens = 50;
          default: dens = 95;
        endcase
      end
      for (int b = 0; b < 3; b++)
        if ($urandom_range(3) == 0) f[b] = ~f[b];
      rdy = ($urandom_range(99) < dens);
      cyc((i == 700 || i == 1400), f, 2'($urandom), CNT_W'($urandom), rdy,
          ($urandom_range(39) == 0));
    end

    repeat (20) cyc(1'b0, 3'b000, 2'd0, 5'd0, 1'b1, 1'b0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
